reg_file: RTL
=============

// Module: reg_file
// PURPOSE
//  Register file that drives the ALU operand inputs (rega/regb) in the 16-bit MIPS datapath.
//  - 2 combinational read ports, 1 synchronous write port (writeback), R0 hardwired to zero.
//  - Post-reset clear sequencer zeroes every entry; busy stalls the pipeline meanwhile.
//  - Holds the carry flag captured from the ALU cout output.
// PARAMETERS
//  DATA_WITH   16   register / operand width in bits
//  ADDR_SIZE   3    register address width
//  NUM_REGS    8    entry count; fixed at 2**ADDR_SIZE, do not override independently
// PORTS
//  clk       in   1          system clock, all state changes on rising edge
//  rst       in   1          synchronous reset, active-high
//  ra_addr   in   ADDR_SIZE  read port A address
//  rb_addr   in   ADDR_SIZE  read port B address
//  rega      out  DATA_WITH  read data A, to ALU rega
//  regb      out  DATA_WITH  read data B, to ALU regb
//  wr_en     in   1          write enable (writeback stage)
//  wr_addr   in   ADDR_SIZE  write address
//  wr_data   in   DATA_WITH  write data
//  flag_we   in   1          load carry flag this cycle
//  cin       in   1          carry from ALU cout
//  carry     out  1          registered carry flag
//  busy      out  1          1 while clear sequence runs; pipeline must stall
// BEHAVIOUR
//  FSM states: CLEAR, RUN. busy = (state==CLEAR), decoded from state, no extra register.
//  Reset (rst=1 at an edge):
//   - state<=CLEAR, clr_idx<=0, carry<=0.
//   - Storage is not touched on the reset edge itself.
//   - rst wins over wr_en and flag_we.
//  CLEAR (rst=0):
//   - Each edge: mem[clr_idx]<=0, clr_idx<=clr_idx+1.
//   - On the edge where clr_idx==NUM_REGS-1, state<=RUN.
//   - busy falls exactly NUM_REGS edges after the first edge with rst=0.
//  Reset mid-clear or in RUN: same as reset; clear restarts at index 0.
//  In CLEAR: wr_en and flag_we are ignored; rega and regb read 0.
//  RUN reads: rega = (ra_addr==0) ? 0 : mem[ra_addr]. regb is the same using rb_addr.
//   - Purely combinational, zero-cycle latency.
//  RUN writes: on an edge with wr_en=1 and wr_addr!=0, mem[wr_addr]<=wr_data.
//   - Writes to address 0 are discarded.
//  RUN flag: on an edge with flag_we=1, carry<=cin; otherwise carry holds.
//  Simultaneous write and read of the same address: see CONFIGURATION.
//  Both read ports addressing the same entry return identical data.
//  clr_idx is ADDR_SIZE wide; its wrap from NUM_REGS-1 to 0 is harmless because the state leaves CLEAR.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//   - In RUN, if wr_en=1, wr_addr!=0 and wr_addr==ra_addr, then rega=wr_data in the same cycle.
//   - regb behaves the same with rb_addr.
//   - Address 0 still reads 0.
//  RF_BYPASS_EN undefined:
//   - Reads return the stored value; new data is visible from the cycle after the write edge.
// TESTING
//  1. rst=1 for 2 cycles, then 0 -> busy=1 for exactly 8 cycles, then 0; carry=0; all entries read 0.
//  2. RUN: write R3=16'h1234, then ra_addr=3, rb_addr=3 -> rega=regb=16'h1234.
//  3. wr_en=1, wr_addr=0, wr_data=16'hFFFF -> ra_addr=0 still reads 16'h0000.
//  4. During CLEAR, wr_en=1 to R5 with 16'hABCD -> after busy falls, R5 reads 16'h0000.
//  5. rst pulsed while clr_idx=4 -> busy stays high 8 more cycles from the release; carry=0.
//  6. R2=16'h0001; same-cycle write R2=16'h00F0 with ra_addr=2:
//     rega=16'h00F0 with RF_BYPASS_EN defined, 16'h0001 without.
//     Also: flag_we=1, cin=1 -> carry=1 next cycle; flag_we=0 -> carry holds.

Source files
------------

// File: rtl/reg_file.sv
// Two-read / one-write register file with R0 hardwired to zero, a post-reset clear sequencer and a carry flag.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module reg_file #(
    parameter int DATA_WITH = 16,
    parameter int ADDR_SIZE = 3,
    parameter int NUM_REGS  = 2**ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] ra_addr,
    input  logic [ADDR_SIZE-1:0] rb_addr,
    output logic [DATA_WITH-1:0] rega,
    output logic [DATA_WITH-1:0] regb,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_WITH-1:0] wr_data,
    input  logic                 flag_we,
    input  logic                 cin,
    output logic                 carry,
    output logic                 busy
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   clr_idx_q, clr_idx_d;
    logic                   carry_q, carry_d;
    logic [DATA_WITH-1:0]   mem_q [NUM_REGS];
    logic [DATA_WITH-1:0]   mem_d [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            carry_q   <= carry_d;
        end
    end

    // Storage has no reset of its own; the clear sequencer zeroes it after rst drops.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == ADDR_SIZE'(NUM_REGS - 1))
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        carry_d = carry_q;
        mem_d   = mem_q;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_d[clr_idx_q] = '0;
            end else begin
                if (wr_en && wr_addr != '0)
                    mem_d[wr_addr] = wr_data;
                if (flag_we)
                    carry_d = cin;
            end
        end
    end

    always_comb begin
        busy  = (state_q == CLEAR);
        carry = carry_q;
    end

    always_comb begin
        rega = '0;
        regb = '0;
        if (state_q == RUN) begin
            if (ra_addr != '0) rega = mem_q[ra_addr];
            if (rb_addr != '0) regb = mem_q[rb_addr];
`ifdef RF_BYPASS_EN
            // A nonzero read address matching wr_addr implies wr_addr != 0.
            if (wr_en && ra_addr != '0 && wr_addr == ra_addr) rega = wr_data;
            if (wr_en && rb_addr != '0 && wr_addr == rb_addr) regb = wr_data;
`endif
        end
    end

endmodule
